// File: rtl/etc_pkg.sv
// -----------------------------------------------------------------------------
// etc_pkg
// Shared definitions for the ETC2 decoded-image scan-out path:
//   - 640x480@60 VGA timing defaults and total-count derivation
//   - RGB565 field positions
//   - frame buffer geometry (14-bit address, 16384 words)
//   - raster flag bundle carried down the output pipeline
// -----------------------------------------------------------------------------
package etc_pkg;

    // VGA timing defaults (pixels / lines)
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    // Image window defaults
    localparam int IMG_W_D  = 128;
    localparam int IMG_H_D  = 128;
    localparam int IMG_X0_D = 256;
    localparam int IMG_Y0_D = 176;

    // RGB565 layout
    localparam int          RGB_W      = 16;
    localparam int          RGB_R_MSB  = 15;
    localparam int          RGB_R_LSB  = 11;
    localparam int          RGB_G_MSB  = 10;
    localparam int          RGB_G_LSB  = 5;
    localparam int          RGB_B_MSB  = 4;
    localparam int          RGB_B_LSB  = 0;
    localparam logic [15:0] BG_COLOR_D = 16'h0000;

    // Frame buffer port B
    localparam int FB_AW    = 14;
    localparam int FB_DEPTH = 1 << FB_AW;
    localparam int BUS_AW   = 32;

    function automatic int total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..total (one spare code keeps end-of-range
    // constants representable even when a porch is zero).
    function automatic int cnt_w(input int tot);
        return $clog2(tot + 1);
    endfunction

    localparam int H_TOTAL_D = total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
    localparam int V_TOTAL_D = total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

    // Raster flags that travel with a pixel through the pipeline
    typedef struct packed {
        logic hs;   // active-low hsync
        logic vs;   // active-low vsync
        logic de;   // inside visible area
        logic win;  // inside image window and armed -> pixel comes from RAM
    } raster_t;

    localparam raster_t RASTER_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0};

endpackage

// File: rtl/etc_img_scanout_if.sv
// -----------------------------------------------------------------------------
// etc_img_scanout_if
// Frame buffer port-B read bus.
//   read_addr   : word address (only [13:0] used)
//   ram_en      : read enable
//   rgb_present : RGB565 read data, valid one cycle after ram_en
// master = scan-out (address side), slave = frame buffer RAM.
// -----------------------------------------------------------------------------
interface etc_img_scanout_if;
    import etc_pkg::*;

    logic [BUS_AW-1:0] read_addr;
    logic              ram_en;
    logic [RGB_W-1:0]  rgb_present;

    modport master (output read_addr, output ram_en, input  rgb_present);
    modport slave  (input  read_addr, input  ram_en, output rgb_present);

endinterface

// File: rtl/etc_vga_timing.sv
// -----------------------------------------------------------------------------
// etc_vga_timing
// Raster counters and S0 decode for a generic VGA mode.
//   i_clk, i_rst_n   : pixel clock, async active-low reset
//   o_h_cnt/o_v_cnt  : current raster position (S0)
//   o_active         : visible area (S0, combinational)
//   o_hs/o_vs        : raw active-low syncs (S0, combinational)
//   o_origin         : counters at (0,0) (S0, combinational)
//   o_frame_start    : registered pulse one cycle after (0,0) (S1)
// -----------------------------------------------------------------------------
module etc_vga_timing
    import etc_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    localparam int HW      = cnt_w(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int VW      = cnt_w(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_origin,
    output logic          o_frame_start
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_frame_start;
    logic          w_origin;

    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_origin;
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_origin      = w_origin;
    assign o_frame_start = r_frame_start;
    assign o_active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_hs          = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign o_vs          = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

endmodule

// File: rtl/etc_img_scanout.sv
// -----------------------------------------------------------------------------
// etc_img_scanout
// VGA scan-out of the decoded ETC2 image held in the frame buffer (port B).
//   vga_clk, rsrt_n  : pixel clock, async active-low reset
//   image_finished   : decoder done (level); sampled once per frame at (0,0)
//   fb               : frame buffer port-B bus (read_addr, ram_en, rgb_present)
//   hsync, vsync, de : active-low syncs and data enable, aligned with vga_rgb
//   vga_rgb          : RGB565 pixel (image, BG_COLOR, or 0 in blanking)
//   frame_start      : one-cycle pulse the cycle after raster (0,0)
// Pipeline: S0 counters/decode, S1 address/enable, S2 RAM read, S3 outputs.
// -----------------------------------------------------------------------------
module etc_img_scanout
    import etc_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_D,
    parameter int          H_FP     = H_FP_D,
    parameter int          H_SYNC   = H_SYNC_D,
    parameter int          H_BP     = H_BP_D,
    parameter int          V_ACTIVE = V_ACTIVE_D,
    parameter int          V_FP     = V_FP_D,
    parameter int          V_SYNC   = V_SYNC_D,
    parameter int          V_BP     = V_BP_D,
    parameter int          IMG_W    = IMG_W_D,
    parameter int          IMG_H    = IMG_H_D,
    parameter int          IMG_X0   = IMG_X0_D,
    parameter int          IMG_Y0   = IMG_Y0_D,
    parameter logic [15:0] BG_COLOR = BG_COLOR_D
) (
    input  logic                vga_clk,
    input  logic                rsrt_n,
    input  logic                image_finished,
    etc_img_scanout_if.master   fb,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [RGB_W-1:0]    vga_rgb,
    output logic                frame_start
);

    localparam int HW = cnt_w(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = cnt_w(total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    localparam logic [HW-1:0] WX0 = HW'(IMG_X0);
    localparam logic [HW-1:0] WX1 = HW'(IMG_X0 + IMG_W);
    localparam logic [VW-1:0] WY0 = VW'(IMG_Y0);
    localparam logic [VW-1:0] WY1 = VW'(IMG_Y0 + IMG_H);

    // The window must sit inside the visible area and fit the buffer.
    if (IMG_X0 + IMG_W > H_ACTIVE || IMG_Y0 + IMG_H > V_ACTIVE) begin : g_bad_window
        $error("etc_img_scanout: image window exceeds active area");
    end
    if (IMG_W * IMG_H > FB_DEPTH) begin : g_bad_size
        $error("etc_img_scanout: image larger than frame buffer");
    end

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_origin;
    logic          w_in_win;
    logic          w_armed;
    logic          w_fetch;
    logic [FB_AW-1:0] w_addr_cur;

    logic             r_armed;
    logic [FB_AW-1:0] r_addr_cnt;
    logic [FB_AW-1:0] r_read_addr;
    logic             r_ram_en;
    raster_t          r_p1;   // S1
    raster_t          r_p2;   // S2, aligned with rgb_present

    etc_vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .i_clk         (vga_clk),
        .i_rst_n       (rsrt_n),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active      (w_active),
        .o_hs          (w_hs),
        .o_vs          (w_vs),
        .o_origin      (w_origin),
        .o_frame_start (frame_start)
    );

    assign w_in_win = (w_h_cnt >= WX0) && (w_h_cnt < WX1) &&
                      (w_v_cnt >= WY0) && (w_v_cnt < WY1);

    // At (0,0) the freshly sampled value applies, so a window touching the
    // origin still sees the new frame's arming.
    assign w_armed    = w_origin ? image_finished : r_armed;
    assign w_fetch    = w_in_win && w_armed;
    // Window pixels are visited in raster order, so a running count gives the
    // linear image address without any row*width product.
    assign w_addr_cur = w_origin ? '0 : r_addr_cnt;

    always_ff @(posedge vga_clk or negedge rsrt_n) begin
        if (!rsrt_n) begin
            r_armed     <= 1'b0;
            r_addr_cnt  <= '0;
            r_read_addr <= '0;
            r_ram_en    <= 1'b0;
            r_p1        <= RASTER_IDLE;
            r_p2        <= RASTER_IDLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            vga_rgb     <= '0;
        end else begin
            if (w_origin)
                r_armed <= image_finished;
            r_addr_cnt  <= w_fetch ? w_addr_cur + 1'b1 : w_addr_cur;
            r_read_addr <= w_fetch ? w_addr_cur : '0;
            r_ram_en    <= w_fetch;
            r_p1        <= '{hs: w_hs, vs: w_vs, de: w_active, win: w_fetch};
            r_p2        <= r_p1;
            hsync       <= r_p2.hs;
            vsync       <= r_p2.vs;
            de          <= r_p2.de;
            vga_rgb     <= r_p2.win ? fb.rgb_present :
                           (r_p2.de ? BG_COLOR : '0);
        end
    end

    assign fb.read_addr = {{(BUS_AW - FB_AW){1'b0}}, r_read_addr};
    assign fb.ram_en    = r_ram_en;

endmodule

// File: tb/tb_etc_img_scanout.sv
// -----------------------------------------------------------------------------
// tb_etc_img_scanout
// Scaled-down raster (56x37 total, 8x8 image at (16,10)) so several frames fit
// in a short run. Two DUTs share stimulus: dut0 with BG_COLOR=0, dut1 with
// BG_COLOR=F800. RAM models return the read address as pixel data.
// -----------------------------------------------------------------------------
module tb_etc_img_scanout;
    import etc_pkg::*;

    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6, HT = HA + HFP + HSY + HBP;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3, VT = VA + VFP + VSY + VBP;
    localparam int IW = 8, IH = 8, IX0 = 16, IY0 = 10;
    localparam int FRAME = HT * VT;
    localparam logic [15:0] BG1 = 16'hF800;
    localparam logic [31:0] RST_VID = {1'b1, 1'b1, 1'b0, 13'b0, 16'h0000};

    logic vga_clk = 1'b0;
    logic rsrt_n = 1'b0;
    logic image_finished = 1'b0;
    always #5 vga_clk = ~vga_clk;

    etc_img_scanout_if fb0();
    etc_img_scanout_if fb1();
    logic hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
    logic [15:0] rgb0, rgb1;

    etc_img_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .IMG_X0(IX0), .IMG_Y0(IY0), .BG_COLOR(16'h0000)
    ) dut0 (
        .vga_clk(vga_clk), .rsrt_n(rsrt_n), .image_finished(image_finished), .fb(fb0),
        .hsync(hs0), .vsync(vs0), .de(de0), .vga_rgb(rgb0), .frame_start(fs0)
    );

    etc_img_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .IMG_X0(IX0), .IMG_Y0(IY0), .BG_COLOR(BG1)
    ) dut1 (
        .vga_clk(vga_clk), .rsrt_n(rsrt_n), .image_finished(image_finished), .fb(fb1),
        .hsync(hs1), .vsync(vs1), .de(de1), .vga_rgb(rgb1), .frame_start(fs1)
    );

    // Synchronous-read RAM: data = address
    always @(posedge vga_clk) if (fb0.ram_en) fb0.rgb_present <= fb0.read_addr[15:0];
    always @(posedge vga_clk) if (fb1.ram_en) fb1.rgb_present <= fb1.read_addr[15:0];

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h >= IX0) && (h < IX0 + IW) && (v >= IY0) && (v < IY0 + IH);
    endfunction

    // Expected {hsync, vsync, de, 13'b0, vga_rgb} for raster position (h,v)
    function automatic logic [31:0] exp_vid(input int h, input int v, input logic armed,
                                            input logic [15:0] bg);
        logic act, hs, vs;
        logic [15:0] rgb;
        act = (h < HA) && (v < VA);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        if (armed && in_win(h, v)) rgb = 16'((v - IY0) * IW + (h - IX0));
        else if (act)              rgb = bg;
        else                       rgb = 16'h0000;
        return {hs, vs, act, 13'b0, rgb};
    endfunction

    // Expected {frame_start, ram_en, 14'b0, read_addr[15:0]} at S1 for (h,v)
    function automatic logic [31:0] exp_s1(input int h, input int v, input logic armed);
        logic en;
        logic [15:0] a;
        en = armed && in_win(h, v);
        a  = en ? 16'((v - IY0) * IW + (h - IX0)) : 16'h0000;
        return {(h == 0 && v == 0), en, 14'b0, a};
    endfunction

    // ---------------- scoreboard monitor (every cycle) ----------------
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int   mh = 0, mv = 0;
    logic marmed = 1'b0;

    initial begin
        forever begin
            @(negedge vga_clk);
            if (!rsrt_n) begin
                mh = 0; mv = 0; marmed = 1'b0;
                // two pipeline stages still hold reset values after release
                q0 = {RST_VID, RST_VID};
                q1 = {RST_VID, RST_VID};
                check("rst_vid0", {hs0, vs0, de0, 13'b0, rgb0}, RST_VID);
                check("rst_s1_0", {fs0, fb0.ram_en, 14'b0, fb0.read_addr[15:0]}, 32'h0);
            end else begin
                if (mh == 0 && mv == 0) marmed = image_finished;
                q0.push_back(exp_vid(mh, mv, marmed, 16'h0000));
                q1.push_back(exp_vid(mh, mv, marmed, BG1));
                check("vid0", {hs0, vs0, de0, 13'b0, rgb0}, q0.pop_front());
                check("vid1", {hs1, vs1, de1, 13'b0, rgb1}, q1.pop_front());
                check("s1_0", {fs0, fb0.ram_en, 14'b0, fb0.read_addr[15:0]}, exp_s1(mh, mv, marmed));
                check("s1_1", {fs1, fb1.ram_en, 14'b0, fb1.read_addr[15:0]}, exp_s1(mh, mv, marmed));
                check("addr_hi", {16'h0, fb0.read_addr[31:16]}, 32'h0);
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else mh++;
            end
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (!fs0 && n < 2 * FRAME);
        check(tag, {31'b0, fs0}, 32'h1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic fin;
        int   h;
        int   v;
        int   kind;   // 0 blanking, 1 background, 2 image pixel
        int   val;    // image pixel value when kind==2
        logic hs;
        logic vs;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int c_hs, c_vs, c_de, c_en, first_hs, first_vs, last_p, p;
        int en_n[2];
        logic seen;
        logic [15:0] e0, e1;

        // raster order within each fin group keeps waits short
        tbl[0]  = '{1'b1, 0,              0,             1, 0,  1'b1, 1'b1};
        tbl[1]  = '{1'b1, HA,             0,             0, 0,  1'b1, 1'b1};
        tbl[2]  = '{1'b1, HA + HFP,       5,             0, 0,  1'b0, 1'b1};
        tbl[3]  = '{1'b1, HA + HFP + HSY, 5,             0, 0,  1'b1, 1'b1};
        tbl[4]  = '{1'b1, IX0 - 1,        IY0,           1, 0,  1'b1, 1'b1};
        tbl[5]  = '{1'b1, IX0,            IY0,           2, 0,  1'b1, 1'b1};
        tbl[6]  = '{1'b1, IX0 + IW,       IY0,           1, 0,  1'b1, 1'b1};
        tbl[7]  = '{1'b1, IX0 + 3,        IY0 + 2,       2, 19, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, IX0 + IW - 1,   IY0 + IH - 1,  2, 63, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, HA - 1,         VA - 1,        1, 0,  1'b1, 1'b1};
        tbl[10] = '{1'b1, 3,              VA + VFP,      0, 0,  1'b1, 1'b0};
        tbl[11] = '{1'b0, IX0,            IY0,           1, 0,  1'b1, 1'b1};
        tbl[12] = '{1'b0, IX0 + IW - 1,   IY0 + IH - 1,  1, 0,  1'b1, 1'b1};

        // ---- reset release with image_finished held high ----
        image_finished = 1'b1;
        repeat (3) @(negedge vga_clk);
        #1 rsrt_n = 1'b1;
        @(negedge vga_clk);
        check("fs_first_cycle", {31'b0, fs0}, 32'h1);
        c_hs = 0; c_vs = 0; c_de = 0; c_en = 0; first_hs = -1; first_vs = -1;
        // edges 1..FRAME: outputs cover exactly one frame's worth of sync/de
        // (two reset cycles stand in for the last two blanking pixels)
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge vga_clk);
            if (!hs0) begin c_hs++; if (first_hs < 0) first_hs = c; end
            if (!vs0) begin c_vs++; if (first_vs < 0) first_vs = c; end
            if (de0) c_de++;
            if (fb0.ram_en) c_en++;
        end
        check("hs_low_total", c_hs, HSY * VT);
        check("vs_low_total", c_vs, VSY * HT);
        check("de_total", c_de, HA * VA);
        check("ram_en_total", c_en, IW * IH);
        check("hs_first_low", first_hs, HA + HFP + 3);
        check("vs_first_low", first_vs, (VA + VFP) * HT + 3);

        // ---- table-driven probe points ----
        last_p = -1;
        for (int i = 0; i < 13; i++) begin
            p = tbl[i].v * HT + tbl[i].h;
            if (i == 0 || tbl[i].fin != tbl[i-1].fin || p <= last_p) begin
                #1 image_finished = tbl[i].fin;
                wait_fs("fs_tbl");
                repeat (2 + p) @(negedge vga_clk);
            end else begin
                repeat (p - last_p) @(negedge vga_clk);
            end
            last_p = p;
            e0 = (tbl[i].kind == 2) ? 16'(tbl[i].val) : 16'h0000;
            e1 = (tbl[i].kind == 2) ? 16'(tbl[i].val) : (tbl[i].kind == 1 ? BG1 : 16'h0000);
            check($sformatf("tbl%0d_dut0", i), {hs0, vs0, de0, 13'b0, rgb0},
                  {tbl[i].hs, tbl[i].vs, tbl[i].kind != 0, 13'b0, e0});
            check($sformatf("tbl%0d_dut1", i), {hs1, vs1, de1, 13'b0, rgb1},
                  {tbl[i].hs, tbl[i].vs, tbl[i].kind != 0, 13'b0, e1});
        end

        // ---- unarmed frame N, image_finished rises at line 14, frame N+1 armed ----
        #1 image_finished = 1'b0;
        wait_fs("fs_frame_n");
        en_n[0] = 0; en_n[1] = 0;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            if (c > 1) @(negedge vga_clk);
            if (fb0.ram_en) en_n[(c > FRAME) ? 1 : 0]++;
            if (c == FRAME + 1) check("fs_frame_n1", {31'b0, fs0}, 32'h1);
            if (c == 14 * HT + 1) #1 image_finished = 1'b1;
        end
        check("ram_en_frame_n", en_n[0], 0);
        check("ram_en_frame_n1", en_n[1], IW * IH);

        // ---- asynchronous reset pulse inside the window at (20,12) ----
        wait_fs("fs_pre_reset");
        repeat (12 * HT + 20) @(negedge vga_clk);
        check("ram_en_before_rst", {31'b0, fb0.ram_en}, 32'h1);
        #1 rsrt_n = 1'b0;
        #1;
        check("async_rst_vid0", {hs0, vs0, de0, 13'b0, rgb0}, RST_VID);
        check("async_rst_vid1", {hs1, vs1, de1, 13'b0, rgb1}, RST_VID);
        check("async_rst_s1", {fs0, fb0.ram_en, 14'b0, fb0.read_addr[15:0]}, 32'h0);
        repeat (3) @(negedge vga_clk);
        #1 rsrt_n = 1'b1;
        @(negedge vga_clk);
        check("fs_after_rst", {31'b0, fs0}, 32'h1);
        c_en = 0; seen = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge vga_clk);
            if (fb0.ram_en) begin
                c_en++;
                if (!seen) begin
                    check("addr_restart", fb0.read_addr, 32'h0);
                    seen = 1'b1;
                end
            end
        end
        check("ram_en_after_rst", c_en, IW * IH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
